// File: rtl/ascensor_sched.sv
// SCAN call scheduler / motion sequencer driving the cab go_up/go_down/halt commands.
// Call-to-motion 2 cycles, arrival-to-halt 0 cycles after the tick edge; no backpressure, calls always latched.
module ascensor_sched #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2,
    parameter int DWELL    = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [N_FLOORS-1:0] call,
    input  logic                floor_tick,
    input  logic                top_lim,
    input  logic                bott_lim,
    output logic                go_up,
    output logic                go_down,
    output logic                halt,
    output logic                door_open,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up
);

    localparam int                 CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DWELL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FLOOR_W-1:0]  r_cur_floor;
    logic [FLOOR_W-1:0]  w_floor_nxt;
    logic [FLOOR_W-1:0]  w_step_floor;
    logic [N_FLOORS-1:0] r_pending;
    logic [N_FLOORS-1:0] w_pending_nxt;
    logic                r_dir_up;
    logic                w_dir_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_above;
    logic                w_below;
    logic                w_clr_en;
    logic [FLOOR_W-1:0]  w_clr_floor;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cur_floor <= '0;
            r_pending   <= '0;
            r_dir_up    <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_floor <= w_floor_nxt;
            r_pending   <= w_pending_nxt;
            r_dir_up    <= w_dir_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_above = 1'b0;
        w_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (r_pending[i] && (i > int'(r_cur_floor))) w_above = 1'b1;
            if (r_pending[i] && (i < int'(r_cur_floor))) w_below = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_cur_floor;
        w_dir_nxt    = r_dir_up;
        w_cnt_nxt    = r_cnt;
        w_clr_en     = 1'b0;
        w_clr_floor  = r_cur_floor;
        w_step_floor = r_cur_floor;

        case (r_state)
            S_IDLE: begin
                if (r_pending[r_cur_floor]) begin
                    w_state_nxt = S_DWELL;
                    w_clr_en    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                end else if (w_above && w_below) begin
                    w_state_nxt = r_dir_up ? S_MOVE_UP : S_MOVE_DOWN;
                end else if (w_above) begin
                    w_state_nxt = S_MOVE_UP;
                    w_dir_nxt   = 1'b1;
                end else if (w_below) begin
                    w_state_nxt = S_MOVE_DOWN;
                    w_dir_nxt   = 1'b0;
                end
            end
            S_MOVE_UP: begin
                // The limit switch is authoritative over the tick-derived floor count.
                if (top_lim) begin
                    w_floor_nxt = TOP_FLOOR;
                    w_clr_floor = TOP_FLOOR;
                    if (r_pending[TOP_FLOOR]) begin
                        w_state_nxt = S_DWELL;
                        w_clr_en    = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (floor_tick) begin
                    w_step_floor = (r_cur_floor == TOP_FLOOR) ? r_cur_floor : r_cur_floor + 1'b1;
                    w_floor_nxt  = w_step_floor;
                    w_clr_floor  = w_step_floor;
                    if (r_pending[w_step_floor]) begin
                        w_state_nxt = S_DWELL;
                        w_clr_en    = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_MOVE_DOWN: begin
                if (bott_lim) begin
                    w_floor_nxt = '0;
                    w_clr_floor = '0;
                    if (r_pending[0]) begin
                        w_state_nxt = S_DWELL;
                        w_clr_en    = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (floor_tick) begin
                    w_step_floor = (r_cur_floor == '0) ? r_cur_floor : r_cur_floor - 1'b1;
                    w_floor_nxt  = w_step_floor;
                    w_clr_floor  = w_step_floor;
                    if (r_pending[w_step_floor]) begin
                        w_state_nxt = S_DWELL;
                        w_clr_en    = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_DWELL: begin
                // Keep clearing the served floor so repeat presses are absorbed.
                w_clr_en = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pending_nxt = r_pending | call;
        if (w_clr_en) w_pending_nxt[w_clr_floor] = 1'b0;
    end

    assign go_up     = (r_state == S_MOVE_UP);
    assign go_down   = (r_state == S_MOVE_DOWN);
    assign halt      = (r_state == S_IDLE) || (r_state == S_DWELL);
    assign door_open = (r_state == S_DWELL);
    assign cur_floor = r_cur_floor;
    assign pending   = r_pending;
    assign dir_up    = r_dir_up;

endmodule

// File: doc/ascensor_sched.md
# ascensor_sched

Call scheduler and motion sequencer for the elevator cab FSM (`ascensor_*`). It latches floor call requests, tracks the cab floor from arrival ticks and the limit switches, and drives the cab's `go_up` / `go_down` / `halt` command inputs. Calls are served with a SCAN policy: keep the current direction while calls remain ahead, then reverse. Door dwell is timed at each served floor. The block sits between the call-button logic and the cab FSM instance, and is the only driver of the cab's command inputs.

## Interface
Parameters:
- `N_FLOORS`, default 4: number of floors, numbered 0 (bottom) to N_FLOORS-1 (top).
- `FLOOR_W`, default 2: width of the floor index; must satisfy 2^FLOOR_W >= N_FLOORS.
- `DWELL`, default 8: number of door-open cycles per served floor; must be >= 1.

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1: clock; every flop samples on the rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `call`  in  N_FLOORS: call request per floor; any cycle with bit i high sets `pending[i]`.
- `floor_tick`  in  1: single-cycle pulse, cab has reached the next floor in its direction of travel.
- `top_lim`  in  1: cab top limit switch (from the cab FSM).
- `bott_lim`  in  1: cab bottom limit switch (from the cab FSM).
- `go_up`  out  1: command cab upward.
- `go_down`  out  1: command cab downward.
- `halt`  out  1: command cab stop.
- `door_open`  out  1: high during dwell.
- `cur_floor`  out  FLOOR_W: tracked cab floor.
- `pending`  out  N_FLOORS: latched, unserved calls.
- `dir_up`  out  1: last travel direction; 1 = up.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DWELL. Command outputs are Moore-decoded from the state register:
  - MOVE_UP: `go_up`=1.
  - MOVE_DOWN: `go_down`=1.
  - IDLE and DWELL: `halt`=1.
  - Invariants: exactly one of `go_up` / `go_down` / `halt` is high in every cycle; `door_open`=1 only in DWELL.
- Reset values: state IDLE, `cur_floor`=0, `pending`=0, `dir_up`=1, `halt`=1, `go_up`=0, `go_down`=0, `door_open`=0, dwell counter=0.
- IDLE decision, evaluated on the registered `pending`, in priority order:
  1. `pending[cur_floor]` set: go to DWELL.
  2. Calls both above and below: move in direction `dir_up`.
  3. Calls only above: go to MOVE_UP and set `dir_up`=1.
  4. Calls only below: go to MOVE_DOWN and clear `dir_up`.
  5. No calls: stay in IDLE.
- MOVE_UP:
  - On `floor_tick`: `cur_floor`+1, saturating at N_FLOORS-1. If `pending` is set at the new floor, go to DWELL.
  - `top_lim`=1: force `cur_floor`=N_FLOORS-1. Go to DWELL if `pending[N_FLOORS-1]` is set, else IDLE.
- MOVE_DOWN: mirror of MOVE_UP. `floor_tick` decrements `cur_floor`, saturating at 0; `bott_lim` forces `cur_floor`=0.
- DWELL:
  - On entry: clear `pending[cur_floor]` and load the counter with DWELL-1.
  - Each cycle: decrement the counter; at 0, go to IDLE.
  - Calls to `cur_floor` during DWELL are absorbed (bit stays 0) and do not restart the counter.
- `floor_tick` in IDLE or DWELL is ignored. Limit switches are ignored in IDLE and DWELL.
- Same-edge set and clear of one `pending` bit: the clear wins.
- Calls to other floors are latched in every state, including during movement and dwell.

## Timing
- Call to motion latency: `call[i]` sampled at edge k, `pending[i]` visible after edge k; `go_up` or `go_down` high after edge k+1 (2 cycles).
- Arrival to stop: `floor_tick` at edge k with a call at the new floor gives `halt`=1 and `door_open`=1 after edge k. `cur_floor` updates at the same edge.
- Door timing: `door_open` stays high for exactly DWELL cycles; IDLE follows for at least 1 cycle before the next motion.
- `RESET` assertion forces all reset values immediately, with no clock edge; this applies mid-move and mid-dwell. Deassertion takes effect at the next rising edge.

## Test plan
- Reset: assert `RESET` -> `halt`=1, `go_up`=0, `go_down`=0, `cur_floor`=0, `pending`=0, `door_open`=0.
- Basic call: at floor 0 pulse `call[2]`, then two `floor_tick`s -> `go_up`=1 two cycles after the call. After the second tick: `cur_floor`=2, `door_open` high for 8 cycles, `pending`=0, then `halt`=1 in IDLE.
- SCAN ordering: moving up at floor 1 with `pending[3]`; pulse `call[0]` -> cab continues up and serves floor 3 first. After dwell, `go_down`=1 and the cab stops at floor 0.
- Call at current floor: at floor 1 in IDLE pulse `call[1]` -> DWELL with no `go_up`/`go_down` pulse. A repeat `call[1]` during dwell is absorbed: the dwell remains 8 cycles and `pending[1]`=0 afterwards.
- Limit override: MOVE_UP with `cur_floor`=1 and `pending[3]`; assert `top_lim` -> `cur_floor`=3, DWELL, `pending[3]` cleared.
- Asynchronous reset: assert `RESET` mid-MOVE_DOWN between clock edges -> `go_down` drops and `halt` rises with no clock edge; `pending` is cleared.
